// File: rtl/rr_grant_sequencer_8_if.sv
// Handshake bundle between the requesting agents and the round-robin grant sequencer.
// The slave modport is the sequencer's view; the master modport is the agents' view.
interface rr_grant_sequencer_8_if;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout_flag;

    modport master (
        output req,
        output done,
        input  grant_valid,
        input  grant_idx,
        input  timeout_flag
    );

    modport slave (
        input  req,
        input  done,
        output grant_valid,
        output grant_idx,
        output timeout_flag
    );
endinterface

// File: rtl/rr_grant_sequencer_8.sv
// 8-requester round-robin arbiter with a grant-hold handshake.
// A grant is held until the holder signals done, withdraws its request, or
// holds it for TIMEOUT cycles. Every grant is followed by at least one idle
// cycle, so the downstream one-hot decoder always passes through all-zero.
module rr_grant_sequencer_8 #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst,
    rr_grant_sequencer_8_if.slave bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // A grant that started with cnt=0 has been valid for TIMEOUT cycles
    // once cnt reaches TIMEOUT-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic       TO_EN   = (TIMEOUT != 0);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       grant_valid_q, grant_valid_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic       timeout_flag_q, timeout_flag_d;

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;
    logic       rel_user;
    logic       rel_to;

    // Round-robin search: first requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release conditions; done or withdrawal masks the timeout pulse.
    always_comb begin
        rel_user = bus.done | ~bus.req[grant_idx_q];
        rel_to   = TO_EN && (cnt_q == TO_LAST);
    end

    // Next-state logic for the IDLE/GRANT sequencer.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        timeout_flag_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d       = S_GRANT;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = pick_idx;
                    cnt_d         = '0;
                end
            end
            S_GRANT: begin
                if (rel_user || rel_to) begin
                    state_d        = S_IDLE;
                    grant_valid_d  = 1'b0;
                    ptr_d          = grant_idx_q + 3'd1;
                    timeout_flag_d = rel_to & ~rel_user;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            cnt_q          <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_idx    = grant_idx_q;
    assign bus.timeout_flag = timeout_flag_q;

endmodule
